load_store_unit: RTL
====================

Name: load_store_unit

Overview:
- Initiator side of the `mem_req_t` data-memory interface, sitting between the execute stage and `data_memory`.
- Accepts one load/store op at a time and issues word-granular requests.
- Performs read-modify-write for byte/halfword stores, and extracts plus sign/zero-extends sub-word loads.
- Detects misaligned and out-of-range addresses and reports them as faults without touching memory.

Parameters:
- MEM_DEPTH, 2048, number of 32-bit words in the attached memory; valid byte addresses are 0 .. 4*MEM_DEPTH-1.

Ports:
- clock  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high.
- op_valid  input  1  op request valid.
- op_ready  output  1  unit can accept an op this cycle.
- op_type  input  3  operation code: 000 LB, 001 LH, 010 LW, 011 LBU, 100 LHU, 101 SB, 110 SH, 111 SW.
- op_addr  input  32  byte address.
- op_wdata  input  32  store data; SB uses [7:0], SH uses [15:0].
- mem_req  output  mem_req_t  to memory: addr (byte address, word-aligned), wen, wdata.
- mem_rdata  input  32  combinational read data from memory for mem_req.addr.
- resp_valid  output  1  one-cycle completion pulse.
- resp_rdata  output  32  load result, extended; 0 for stores and faults.
- resp_misaligned  output  1  valid with resp_valid; alignment fault.
- resp_range_fault  output  1  valid with resp_valid; address >= 4*MEM_DEPTH.

Behaviour:
- States: IDLE, READ, RMW_READ, RMW_WRITE, WRITE, RESP.
- op_ready = (state==IDLE) && !reset.
- Accept: on a posedge with op_valid && op_ready, latch op_type, op_addr and op_wdata.
- Misaligned rule: LH/LHU/SH with addr[0]!=0, or LW/SW with addr[1:0]!=0.
- Transitions from IDLE on accept:
  - Misaligned or out of range -> RESP with the corresponding flag set. Misaligned has priority, so only one flag is ever set.
  - Else LB/LH/LW/LBU/LHU -> READ.
  - Else SB/SH -> RMW_READ.
  - Else SW -> WRITE.
- READ -> RESP: capture mem_rdata into resp_rdata.
  - Byte k = word[8k+7:8k] with k=addr[1:0].
  - Half h = word[16h+15:16h] with h=addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- RMW_READ -> RMW_WRITE: capture mem_rdata into a merge register.
- RMW_WRITE -> RESP: wen=1; wdata = merge register with the target lane replaced by op_wdata[7:0] or [15:0].
- WRITE -> RESP: wen=1; wdata = op_wdata.
- RESP -> IDLE: resp_valid=1 for exactly this cycle; flags and resp_rdata hold until the next RESP.
- Latency (accept posedge = cycle 0), resp_valid high in:
  - loads and SW: cycle 2;
  - SB/SH: cycle 3;
  - faults: cycle 1.
- mem_req.addr = {latched_addr[31:2], 2'b00} in every non-IDLE state, 0 in IDLE.
- mem_req.wen is high only in WRITE/RMW_WRITE, and is combinationally gated by !reset. Memory commits on negedge, so the write completes within the state cycle.
- mem_req.wdata = 0 when wen=0.
- No memory write is ever issued for a faulting op. Faults do not stall; the unit returns to IDLE normally.
- Reset, whether mid-operation or idle: state -> IDLE; resp_valid, resp_rdata, resp_misaligned and resp_range_fault -> 0; latched op cleared; wen low during the reset cycle. A pending RMW is abandoned with no partial write.
- op_valid while !op_ready is ignored. The requester holds the op until op_ready, and the unit never buffers a second op.
- Range check uses the full 32-bit address: e.g. 0x0000_2000 faults at the default depth, as does any address with upper bits set.

Test Plan:
- Reset, then SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> memory word 4 = 0xDEADBEEF; LW resp_valid at cycle 2 with resp_rdata 0xDEADBEEF.
- With word 4 = 0xDEADBEEF: LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x10 -> 0xFFFFBEEF; LHU 0x12 -> 0x0000DEAD.
- With word 4 = 0xDEADBEEF: SB 0x11 data 0x55 -> word 4 = 0xDEAD55EF, resp at cycle 3; SH 0x12 data 0x1234 -> word 4 = 0x123455EF.
- LW 0x11, SH 0x13, LH 0x21 -> resp at cycle 1 with resp_misaligned=1; wen never asserted; memory unchanged.
- SW 0x2000 and LW 0xFFFF_FFFC at MEM_DEPTH=2048 -> resp_range_fault=1, resp_misaligned=0, no write.
- Assert reset during RMW_WRITE of SB 0x20 data 0xAA over word 0x11223344 -> wen low, memory cleared by its own reset, resp_valid stays 0, op_ready=1 the cycle after reset deasserts; back-to-back op_valid held high yields responses spaced by the exact per-op latencies.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: drives word-granular data-memory requests for one op at a time,
// merging sub-word stores via read-modify-write and extending sub-word loads.
package lsu_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
  } mem_req_t;
endpackage

// state       | meaning
// IDLE        | waiting for an op; op_ready high
// READ        | load word presented by memory, extract and extend
// RMW_READ    | capture the word a sub-word store will merge into
// RMW_WRITE   | write merged word back
// WRITE       | full-word store
// RESP        | one-cycle completion pulse
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_DEPTH = 2048
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [2:0]  op_type,
  input  logic [31:0] op_addr,
  input  logic [31:0] op_wdata,
  output mem_req_t    mem_req,
  input  logic [31:0] mem_rdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_misaligned,
  output logic        resp_range_fault
);

  localparam logic [2:0] OP_LB  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LW  = 3'b010;
  localparam logic [2:0] OP_LBU = 3'b011;
  localparam logic [2:0] OP_LHU = 3'b100;
  localparam logic [2:0] OP_SB  = 3'b101;
  localparam logic [2:0] OP_SH  = 3'b110;
  localparam logic [2:0] OP_SW  = 3'b111;

  localparam logic [32:0] ADDR_LIMIT = 33'(4 * MEM_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_RMW_READ,
    S_RMW_WRITE,
    S_WRITE,
    S_RESP
  } state_t;

  state_t      r_state;
  logic [2:0]  r_op_type;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_merge;
  logic        r_resp_valid;
  logic [31:0] r_resp_rdata;
  logic        r_resp_misaligned;
  logic        r_resp_range_fault;

  logic        w_misaligned;
  logic        w_out_of_range;
  logic        w_is_load;
  logic        w_is_sub_store;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic [31:0] w_merged;

  always_comb begin
    w_misaligned = 1'b0;
    case (op_type)
      OP_LH, OP_LHU, OP_SH: w_misaligned = op_addr[0];
      OP_LW, OP_SW:         w_misaligned = |op_addr[1:0];
      default:              w_misaligned = 1'b0;
    endcase
  end

  // Full-width compare so any upper address bit counts as out of range.
  assign w_out_of_range = ({1'b0, op_addr} >= ADDR_LIMIT);
  assign w_is_load      = (op_type <= OP_LHU);
  assign w_is_sub_store = (op_type == OP_SB) || (op_type == OP_SH);

  always_comb begin
    w_byte = mem_rdata[7:0];
    case (r_addr[1:0])
      2'd0: w_byte = mem_rdata[7:0];
      2'd1: w_byte = mem_rdata[15:8];
      2'd2: w_byte = mem_rdata[23:16];
      2'd3: w_byte = mem_rdata[31:24];
      default: w_byte = mem_rdata[7:0];
    endcase
    w_half = r_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (r_op_type)
      OP_LB:   w_load = {{24{w_byte[7]}}, w_byte};
      OP_LH:   w_load = {{16{w_half[15]}}, w_half};
      OP_LBU:  w_load = {24'd0, w_byte};
      OP_LHU:  w_load = {16'd0, w_half};
      default: w_load = mem_rdata;
    endcase
  end

  always_comb begin
    w_merged = r_merge;
    if (r_op_type == OP_SB) begin
      case (r_addr[1:0])
        2'd0: w_merged[7:0]   = r_wdata[7:0];
        2'd1: w_merged[15:8]  = r_wdata[7:0];
        2'd2: w_merged[23:16] = r_wdata[7:0];
        2'd3: w_merged[31:24] = r_wdata[7:0];
        default: w_merged = r_merge;
      endcase
    end else if (r_addr[1]) begin
      w_merged[31:16] = r_wdata[15:0];
    end else begin
      w_merged[15:0] = r_wdata[15:0];
    end
  end

  assign op_ready = (r_state == S_IDLE) && !reset;

  // Write enable is gated by reset directly so an abandoned RMW never commits.
  always_comb begin
    mem_req = '0;
    if (r_state != S_IDLE) begin
      mem_req.addr = {r_addr[31:2], 2'b00};
    end
    if (!reset && (r_state == S_WRITE)) begin
      mem_req.wen   = 1'b1;
      mem_req.wdata = r_wdata;
    end else if (!reset && (r_state == S_RMW_WRITE)) begin
      mem_req.wen   = 1'b1;
      mem_req.wdata = w_merged;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state            <= S_IDLE;
      r_op_type          <= '0;
      r_addr             <= '0;
      r_wdata            <= '0;
      r_merge            <= '0;
      r_resp_valid       <= 1'b0;
      r_resp_rdata       <= '0;
      r_resp_misaligned  <= 1'b0;
      r_resp_range_fault <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (op_valid) begin
            r_op_type <= op_type;
            r_addr    <= op_addr;
            r_wdata   <= op_wdata;
            if (w_misaligned || w_out_of_range) begin
              r_state            <= S_RESP;
              r_resp_valid       <= 1'b1;
              r_resp_rdata       <= '0;
              r_resp_misaligned  <= w_misaligned;
              r_resp_range_fault <= !w_misaligned;
            end else if (w_is_load) begin
              r_state <= S_READ;
            end else if (w_is_sub_store) begin
              r_state <= S_RMW_READ;
            end else begin
              r_state <= S_WRITE;
            end
          end
        end
        S_READ: begin
          r_state            <= S_RESP;
          r_resp_valid       <= 1'b1;
          r_resp_rdata       <= w_load;
          r_resp_misaligned  <= 1'b0;
          r_resp_range_fault <= 1'b0;
        end
        S_RMW_READ: begin
          r_merge <= mem_rdata;
          r_state <= S_RMW_WRITE;
        end
        S_RMW_WRITE, S_WRITE: begin
          r_state            <= S_RESP;
          r_resp_valid       <= 1'b1;
          r_resp_rdata       <= '0;
          r_resp_misaligned  <= 1'b0;
          r_resp_range_fault <= 1'b0;
        end
        S_RESP: begin
          r_state      <= S_IDLE;
          r_resp_valid <= 1'b0;
        end
        default: begin
          r_state      <= S_IDLE;
          r_resp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign resp_valid       = r_resp_valid;
  assign resp_rdata       = r_resp_rdata;
  assign resp_misaligned  = r_resp_misaligned;
  assign resp_range_fault = r_resp_range_fault;

endmodule
